cic3_sample_buffer: RTL



---
 rtl/cic3_buf_pkg.sv | 25 ++
 rtl/cic3_buf_fifo.sv | 83 ++++++++
 rtl/cic3_sample_buffer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cic3_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cic3_buf_pkg
//  Description : Shared constants and types for the CIC3 post-decimation
//                sample buffer (state encoding, word widths).
//  Optional    : CIC3_BUF_DROP_CNT_EN uses DROP_CNT_WIDTH for the drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cic3_buf_pkg;

    // Width of the CIC decimator output word
    localparam int CIC_WIDTH      = 25;

    // Width of the optional saturating dropped-sample counter
    localparam int DROP_CNT_WIDTH = 8;

    // Capture state machine encoding
    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        FLUSH    = 2'd1,
        RUN      = 2'd2
    } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/cic3_buf_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cic3_buf_fifo
//  Description : Single-clock show-ahead FIFO. A push into a full FIFO is
//                accepted only when a pop happens in the same cycle;
//                otherwise it is rejected and o_drop pulses.
//  Ports       : clk, reset_n      - clock, async active-low reset
//                i_clear           - synchronous flush (pointers, level)
//                i_push/i_push_data- write request and word
//                i_rd_ready        - consumer accepts head word
//                o_rd_valid/o_rd_data - head word, zero when empty
//                o_level           - stored word count
//                o_drop            - push rejected this cycle (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module cic3_buf_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_rd_ready,
    output logic                     o_rd_valid,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_drop
);

    localparam int            c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_level;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_full);
    // A flush overrides any handshake in the same cycle
    assign w_pop   = i_rd_ready & ~w_empty & ~i_clear;
    // Full is fine as long as the head leaves on the same edge
    assign w_wr    = i_push & ~i_clear & (~w_full | w_pop);
    assign o_drop  = i_push & ~i_clear & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_push_data;
    end

    assign o_rd_valid = ~w_empty;
    assign o_rd_data  = w_empty ? '0 : r_mem[r_rptr];
    assign o_level    = r_level;

endmodule
`default_nettype wire

// File: rtl/cic3_sample_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : cic3_sample_buffer
//  Description : Detects each new CIC decimated word in the modulator clock
//                domain, discards the CIC start-up transient and queues the
//                remaining samples for a valid/ready reader. Drops on a full
//                FIFO set a sticky overflow flag.
//  Ports       : clk, reset_n       - clock, async active-low reset
//                enable             - capture enable
//                cic_data           - CIC output word
//                cic_sample_clk     - CIC divided clock, sampled as data
//                rd_ready/rd_valid/rd_data - show-ahead read handshake
//                fifo_level         - stored sample count
//                overflow           - sticky drop flag
//                clear_overflow     - synchronous clear of overflow/drop_count
//                drop_count         - saturating drop counter (optional)
//  Config      : `define CIC3_BUF_DROP_CNT_EN adds the drop_count port.
//  Revision    : 1.0 - initial release
// ============================================================================
module cic3_sample_buffer
    import cic3_buf_pkg::*;
#(
    parameter int WIDTH   = CIC_WIDTH,
    parameter int DEPTH   = 16,
    parameter int DISCARD = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [WIDTH-1:0]           cic_data,
    input  logic                       cic_sample_clk,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    input  logic                       clear_overflow
`ifdef CIC3_BUF_DROP_CNT_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0]  drop_count
`endif
);

    localparam int                 c_disc_w    = (DISCARD < 2) ? 1 : $clog2(DISCARD + 1);
    localparam logic [c_disc_w-1:0] c_disc_last = c_disc_w'((DISCARD > 0) ? (DISCARD - 1) : 0);

    buf_state_t          r_state;
    buf_state_t          w_state_next;
    logic [c_disc_w-1:0] r_disc_cnt;
    logic [c_disc_w-1:0] w_disc_next;

    logic             r_sc_q;
    logic             r_edge_p;
    logic             r_cap_p;
    logic [WIDTH-1:0] r_cap_data;
    logic             r_overflow;

    logic w_rise;
    logic w_active;
    logic w_push;
    logic w_drop;

    assign w_rise   = cic_sample_clk & ~r_sc_q;
    // Leaving enable low for even one edge abandons everything in flight
    assign w_active = enable & (r_state != DISABLED);
    assign w_push   = r_cap_p & w_active & (r_state == RUN);

    // ------------------------------------------------------------------
    // Edge detect and capture. The CIC output register is ripple-clocked
    // from the divided clock, so the word is taken one cycle after the
    // edge is seen to let it settle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sc_q     <= 1'b0;
            r_edge_p   <= 1'b0;
            r_cap_p    <= 1'b0;
            r_cap_data <= '0;
        end else begin
            r_sc_q   <= cic_sample_clk;
            r_edge_p <= w_rise & w_active;
            r_cap_p  <= r_edge_p & w_active;
            if (r_edge_p) r_cap_data <= cic_data;
        end
    end

    // ------------------------------------------------------------------
    // State machine: register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= DISABLED;
            r_disc_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_disc_cnt <= w_disc_next;
        end
    end

    // ------------------------------------------------------------------
    // State machine: next state and discard counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_disc_next  = r_disc_cnt;
        if (!enable) begin
            w_state_next = DISABLED;
            w_disc_next  = '0;
        end else begin
            case (r_state)
                DISABLED: begin
                    w_disc_next  = '0;
                    w_state_next = (DISCARD == 0) ? RUN : FLUSH;
                end
                FLUSH: begin
                    if (r_cap_p) begin
                        if (r_disc_cnt == c_disc_last) w_state_next = RUN;
                        else                           w_disc_next  = r_disc_cnt + 1'b1;
                    end
                end
                RUN: begin
                    w_state_next = RUN;
                end
                default: begin
                    w_state_next = DISABLED;
                    w_disc_next  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sample FIFO; held empty whenever capture is inactive
    // ------------------------------------------------------------------
    cic3_buf_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (~w_active),
        .i_push      (w_push),
        .i_push_data (r_cap_data),
        .i_rd_ready  (rd_ready),
        .o_rd_valid  (rd_valid),
        .o_rd_data   (rd_data),
        .o_level     (fifo_level),
        .o_drop      (w_drop)
    );

    // A drop in the same cycle as a clear request keeps the flag set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            r_overflow <= 1'b0;
        else if (w_drop)         r_overflow <= 1'b1;
        else if (clear_overflow) r_overflow <= 1'b0;
    end

    assign overflow = r_overflow;

`ifdef CIC3_BUF_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
        end else if (clear_overflow) begin
            r_drop_cnt <= '0;
        end
    end

    assign drop_count = r_drop_cnt;
`endif

endmodule
`default_nettype wire
